// File: rtl/mode_sequencer_if.sv
// Panel-side bundle for mode_sequencer: debounced buttons and timebase in,
// one-hot/binary mode and event pulses out.
interface mode_sequencer_if #(
  parameter int unsigned NUM_MODES = 5
);
  localparam int unsigned IDX_W = $clog2(NUM_MODES);

  logic                 MODE;
  logic                 BACK;
  logic                 TICK;
  logic [NUM_MODES-1:0] CURRENT_STATE;
  logic [IDX_W-1:0]     MODE_IDX;
  logic                 CHANGED;
  logic                 TIMEOUT_EVT;

  modport master (
    output MODE,
    output BACK,
    output TICK,
    input  CURRENT_STATE,
    input  MODE_IDX,
    input  CHANGED,
    input  TIMEOUT_EVT
  );

  modport slave (
    input  MODE,
    input  BACK,
    input  TICK,
    output CURRENT_STATE,
    output MODE_IDX,
    output CHANGED,
    output TIMEOUT_EVT
  );
endinterface

// File: rtl/mode_sequencer.sv
// N-mode one-hot ring with forward/back button stepping and edge detection.
// Define MODE_SEQ_TIMEOUT_EN to enable the idle TICK counter that returns to home.
module mode_sequencer #(
  parameter int unsigned NUM_MODES     = 5,
  parameter int unsigned TIMEOUT_TICKS = 30
) (
  input  logic          CLK,
  input  logic          RESET_N,
  mode_sequencer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_MODES);
  localparam logic [IDX_W-1:0]     LastIdx = IDX_W'(NUM_MODES - 1);
  localparam logic [NUM_MODES-1:0] Home    = NUM_MODES'(1);

  logic                 mode_q, back_q;
  logic [NUM_MODES-1:0] state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 changed_q, changed_d;
  logic                 evt_q, evt_d;
  logic                 mode_rise, back_rise, any_rise, legal, expire;

  assign mode_rise = bus.MODE & ~mode_q;
  assign back_rise = bus.BACK & ~back_q;
  assign any_rise  = mode_rise | back_rise;
  assign legal     = $onehot(state_q);

`ifdef MODE_SEQ_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (any_rise || !legal || (state_q == Home)) begin
      cnt_d = 8'd0;
    end else if (bus.TICK) begin
      // Expire on the tick that would make the count equal TIMEOUT_TICKS.
      if (cnt_q == 8'(TIMEOUT_TICKS - 1)) begin
        expire = 1'b1;
        cnt_d  = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unsigned unused_timeout_ticks = TIMEOUT_TICKS;
  logic unused_tick;
  assign unused_tick = bus.TICK;
  assign expire      = 1'b0;
`endif

  always_comb begin
    idx_d = idx_q;
    evt_d = 1'b0;
    if (!legal) begin
      idx_d = '0;
    end else if (mode_rise && back_rise) begin
      idx_d = idx_q;
    end else if (mode_rise) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end else if (back_rise) begin
      idx_d = (idx_q == '0) ? LastIdx : idx_q - 1'b1;
    end else if (expire) begin
      idx_d = '0;
      evt_d = 1'b1;
    end
    state_d   = Home << idx_d;
    changed_d = (state_d != state_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q    <= 1'b0;
      back_q    <= 1'b0;
      state_q   <= Home;
      idx_q     <= '0;
      changed_q <= 1'b0;
      evt_q     <= 1'b0;
    end else begin
      mode_q    <= bus.MODE;
      back_q    <= bus.BACK;
      state_q   <= state_d;
      idx_q     <= idx_d;
      changed_q <= changed_d;
      evt_q     <= evt_d;
    end
  end

  assign bus.CURRENT_STATE = state_q;
  assign bus.MODE_IDX      = idx_q;
  assign bus.CHANGED       = changed_q;
  assign bus.TIMEOUT_EVT   = evt_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer (NUM_MODES=5, TIMEOUT_TICKS=3); expectations
// follow MODE_SEQ_TIMEOUT_EN when it is defined for the build.
module tb_mode_sequencer;
  localparam int unsigned N  = 5;
  localparam int unsigned TT = 3;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;

  mode_sequencer_if #(.NUM_MODES(N)) bus ();

  mode_sequencer #(
    .NUM_MODES    (N),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // {CURRENT_STATE, MODE_IDX, CHANGED, TIMEOUT_EVT}
  logic [9:0] obs;
  assign obs = {bus.CURRENT_STATE, bus.MODE_IDX, bus.CHANGED, bus.TIMEOUT_EVT};

  function automatic logic [9:0] exp_v(input int idx, input logic chg, input logic evt);
    logic [4:0] oh;
    oh = 5'b00001 << idx;
    return {oh, 3'(idx), chg, evt};
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    bus.MODE = 1'b0; bus.BACK = 1'b0; bus.TICK = 1'b0;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    e = exp_v(0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset: got %b want %b", obs, e); end
    RESET_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, e); end
  endtask

  task automatic test_forward();
    logic [9:0] e;
    int pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      bus.MODE = 1'b1;
      @(negedge CLK);
      if (bus.CHANGED === 1'b1) pulses++;
      e = exp_v(i % 5, 1'b1, 1'b0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL fwd_step%0d: got %b want %b", i, obs, e); end
      bus.MODE = 1'b0;
      @(negedge CLK);
      if (bus.CHANGED === 1'b1) pulses++;
      e = exp_v(i % 5, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL fwd_idle%0d: got %b want %b", i, obs, e); end
    end
    n_checks++;
    if (pulses !== 5) begin n_fail++; $display("FAIL fwd_pulses: got %0d want 5", pulses); end
  endtask

  task automatic test_back();
    logic [9:0] e;
    bus.BACK = 1'b1;
    @(negedge CLK);
    e = exp_v(4, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL back_wrap: got %b want %b", obs, e); end
    e = exp_v(4, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL back_hold%0d: got %b want %b", c, obs, e); end
    end
    bus.BACK = 1'b0;
    @(negedge CLK);
    // Walk 4 -> 0 -> 1 -> 2 for the following scenarios.
    for (int i = 0; i < 3; i++) begin
      bus.MODE = 1'b1;
      @(negedge CLK);
      e = exp_v(i, 1'b1, 1'b0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL back_walk%0d: got %b want %b", i, obs, e); end
      bus.MODE = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] e;
    bus.MODE = 1'b1; bus.BACK = 1'b1;
    @(negedge CLK);
    e = exp_v(2, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL simul_press: got %b want %b", obs, e); end
    bus.MODE = 1'b0; bus.BACK = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL simul_after: got %b want %b", obs, e); end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    for (int t = 1; t <= 3; t++) begin
      bus.TICK = 1'b1;
      @(negedge CLK);
      bus.TICK = 1'b0;
`ifdef MODE_SEQ_TIMEOUT_EN
      e = (t == 3) ? exp_v(0, 1'b1, 1'b1) : exp_v(2, 1'b0, 1'b0);
`else
      e = exp_v(2, 1'b0, 1'b0);
`endif
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL tmo_tick%0d: got %b want %b", t, obs, e); end
      @(negedge CLK);
`ifdef MODE_SEQ_TIMEOUT_EN
      e = (t == 3) ? exp_v(0, 1'b0, 1'b0) : exp_v(2, 1'b0, 1'b0);
`else
      e = exp_v(2, 1'b0, 1'b0);
`endif
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL tmo_idle%0d: got %b want %b", t, obs, e); end
    end
`ifdef MODE_SEQ_TIMEOUT_EN
    for (int i = 1; i <= 2; i++) begin
      bus.MODE = 1'b1;
      @(negedge CLK);
      bus.MODE = 1'b0;
      @(negedge CLK);
      e = exp_v(i, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL tmo_rewalk%0d: got %b want %b", i, obs, e); end
    end
`endif
    // Two ticks, then a MODE rise together with the third: the step wins.
    for (int t = 0; t < 2; t++) begin
      bus.TICK = 1'b1;
      @(negedge CLK);
      bus.TICK = 1'b0;
      @(negedge CLK);
    end
    bus.TICK = 1'b1; bus.MODE = 1'b1;
    @(negedge CLK);
    bus.TICK = 1'b0; bus.MODE = 1'b0;
    e = exp_v(3, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL tmo_race: got %b want %b", obs, e); end
    bus.TICK = 1'b1;
    @(negedge CLK);
    bus.TICK = 1'b0;
    @(negedge CLK);
    e = exp_v(3, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL tmo_cleared: got %b want %b", obs, e); end
  endtask

  task automatic test_illegal();
    logic [9:0] e;
    force dut.state_q = 5'b00110;
    #1;
    release dut.state_q;
    @(negedge CLK);
    e = exp_v(0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL illegal_recover: got %b want %b", obs, e); end
    @(negedge CLK);
    e = exp_v(0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL illegal_after: got %b want %b", obs, e); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    for (int i = 0; i < 2; i++) begin
      bus.MODE = 1'b1;
      @(negedge CLK);
      bus.MODE = 1'b0;
      @(negedge CLK);
    end
    bus.MODE = 1'b1;
    @(posedge CLK);
    #2;
    e = exp_v(3, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_pre: got %b want %b", obs, e); end
    RESET_N = 1'b0;
    #1;
    e = exp_v(0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_async: got %b want %b", obs, e); end
    @(negedge CLK);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_held: got %b want %b", obs, e); end
    RESET_N = 1'b1;
    @(negedge CLK);
    e = exp_v(1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_held_button: got %b want %b", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    bus.MODE = 1'b0;
    @(negedge CLK);
    e = exp_v(1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_low0: got %b want %b", obs, e); end
    for (int i = 2; i <= 3; i++) begin
      bus.MODE = 1'b1;
      @(negedge CLK);
      e = exp_v(i, 1'b1, 1'b0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b_rise%0d: got %b want %b", i, obs, e); end
      bus.MODE = 1'b0;
      @(negedge CLK);
      e = exp_v(i, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b_low%0d: got %b want %b", i, obs, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_back();
    test_simultaneous();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
